// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM states, grant owner and the RAM read latency.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_e;

    typedef enum logic {
        GNT_VID,
        GNT_CPU
    } gnt_e;

    // Cycles from the RAM sampling its address to ram_rdata being valid.
    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/vram_arbiter_if.sv
// Video fetch, CPU bus and RAM primitive signals of the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // Arbiter side.
    modport slave (
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    // Requesters and RAM primitive side.
    modport master (
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between the video fetcher (priority) and the CPU;
// a starvation counter lets the CPU win once after CPU_MAX_WAIT lost arbitrations.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW           = 13,
    parameter int DW           = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus,
    output logic          busy
);

    localparam int            SW         = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_MAX_WAIT);

    state_e        state_q, state_d;
    gnt_e          gnt_q, gnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_wins;

    // NOTE: every variable gets a default at the top so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        starve_d    = starve_q;
        wr_d        = wr_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_wins    = bus.cpu_req && (!bus.vid_req || (starve_q >= STARVE_MAX));

        unique case (state_q)
            ST_IDLE: begin
                if (bus.vid_req || bus.cpu_req) begin
                    state_d     = ST_ISSUE;
                    ram_wdata_d = bus.cpu_wdata;
                    if (cpu_wins) begin
                        gnt_d      = GNT_CPU;
                        ram_addr_d = bus.cpu_addr;
                        ram_we_d   = bus.cpu_we;
                        wr_d       = bus.cpu_we;
                        starve_d   = '0;
                    end else begin
                        gnt_d      = GNT_VID;
                        ram_addr_d = bus.vid_addr;
                        wr_d       = 1'b0;
                        // A lost arbitration only counts while the CPU is actually waiting.
                        if (bus.cpu_req && (starve_q < STARVE_MAX)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d = ST_ACK;
                if (gnt_q == GNT_VID) begin
                    vid_rdata_d = bus.ram_rdata;
                end else if (!wr_q) begin
                    cpu_rdata_d = bus.ram_rdata;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_VID;
            starve_q    <= '0;
            wr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            starve_q    <= starve_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.vid_rdata = vid_rdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_ack   = (state_q == ST_ACK) && (gnt_q == GNT_VID);
    assign bus.cpu_ack   = (state_q == ST_ACK) && (gnt_q == GNT_CPU);
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, hand-written corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int AW           = 13;
    localparam int DW           = 8;
    localparam int CPU_MAX_WAIT = 4;
    localparam int LAT_BOUND    = (CPU_MAX_WAIT + 1) * 4 + 3;
    localparam int DEPTH        = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   both_ack_cycles = 0;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 37 + 11) & 255);
    endfunction

    // Synchronous single-port RAM primitive with RAM_RD_LAT cycles of read latency.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe [RAM_RD_LAT];
    assign bus.ram_rdata = rd_pipe[RAM_RD_LAT-1];

    initial begin : ram_model
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]            = pat(i);
            mem[13'h1FF0 + i] = pat(i + 16);
        end
        mem[13'h1ABC] = 8'h5A;
        for (int i = 0; i < RAM_RD_LAT; i++) rd_pipe[i] = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            rd_pipe[0] <= mem[bus.ram_addr];
            for (int i = RAM_RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    always @(negedge clk) if (bus.vid_ack && bus.cpu_ack) both_ack_cycles++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] r;
        r = AW'($urandom_range(15));
        return ($urandom_range(1) == 1) ? (13'h1FF0 | r) : r;
    endfunction

    // One isolated access from an idle arbiter; drops the request in the ack cycle.
    task automatic run_txn(input logic is_cpu, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int lat, output int we_cyc,
                           output logic got_vid, output logic got_cpu);
        lat = 0; we_cyc = 0; got_vid = 1'b0; got_cpu = 1'b0;
        if (is_cpu) begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end else begin
            bus.vid_req = 1'b1; bus.vid_addr = addr;
        end
        while (lat < 12 && !(got_vid || got_cpu)) begin
            step();
            lat++;
            if (bus.ram_we) we_cyc++;
            got_vid = bus.vid_ack;
            got_cpu = bus.cpu_ack;
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        step();
    endtask

    typedef struct {
        logic          is_cpu;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs [8];
    logic [DW-1:0] shadow [DEPTH];

    initial begin : main
        int            lat, we_cyc, n, cyc, last_cpu, o;
        logic          got_vid, got_cpu;
        logic [9:0]    seq;
        int            free_at, p_cyc, starve_m, cpu_start;
        logic          p_cpu, p_we, e_vack, e_cack, e_busy, e_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata, exp_vrd, exp_crd;

        //            is_cpu we    addr      wdata  exp_rdata
        vecs[0] = '{1'b0, 1'b0, 13'h1ABC, 8'h00, 8'h5A};
        vecs[1] = '{1'b1, 1'b1, 13'h0123, 8'hC3, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 13'h0123, 8'h00, 8'hC3};
        vecs[3] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'hC3};
        vecs[4] = '{1'b1, 1'b1, 13'h1FFF, 8'hFF, 8'hC3};
        vecs[5] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 13'h0000, 8'hA5, 8'hC3};
        vecs[7] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'hA5};

        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        for (int i = 0; i < 16; i++) begin
            shadow[i]            = pat(i);
            shadow[13'h1FF0 + i] = pat(i + 16);
        end
        shadow[13'h1ABC] = 8'h5A;

        reset = 1'b1;
        idle_inputs();
        step();
        step();
        check("reset state", dut.state_q, ST_IDLE);
        check("reset ack/busy/we", {bus.vid_ack, bus.cpu_ack, busy, bus.ram_we}, 4'b0000);
        check("reset ram_addr", bus.ram_addr, 0);
        check("reset ram_wdata", bus.ram_wdata, 0);
        check("reset rdata", {bus.vid_rdata, bus.cpu_rdata}, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].is_cpu, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, we_cyc, got_vid, got_cpu);
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d ack owner", i), {got_vid, got_cpu},
                  {!vecs[i].is_cpu, vecs[i].is_cpu});
            check($sformatf("vec%0d ram_we cycles", i), we_cyc,
                  (vecs[i].is_cpu && vecs[i].we) ? 1 : 0);
            check($sformatf("vec%0d rdata", i),
                  vecs[i].is_cpu ? bus.cpu_rdata : bus.vid_rdata, vecs[i].exp_rdata);
            if (vecs[i].is_cpu && vecs[i].we) shadow[vecs[i].addr] = vecs[i].wdata;
        end

        // Contention: both requests rise together with starve count 0 and stay high.
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0005;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0006;
        seq = '0; n = 0; cyc = 0; last_cpu = -1;
        while (n < 10 && cyc < 80) begin
            step();
            cyc++;
            if (cyc == 1) check("starve after first grant", dut.starve_q, 1);
            if (bus.vid_ack || bus.cpu_ack) begin
                seq[n] = bus.cpu_ack;
                n++;
                if (bus.cpu_ack) begin
                    check("contention cpu rdata", bus.cpu_rdata, shadow[6]);
                    if (last_cpu >= 0) check("cpu ack spacing <= 23", (cyc - last_cpu) <= 23, 1);
                    last_cpu = cyc;
                end else begin
                    check("contention vid rdata", bus.vid_rdata, shadow[5]);
                end
            end
        end
        check("contention grant count", n, 10);
        check("contention grant order", seq, 10'b1000010000);
        idle_inputs();
        step();
        step();

        // Reset in the WAIT cycle of a CPU write: no ack, then the held request is re-served.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0042; bus.cpu_wdata = 8'h77;
        step();
        check("mid-write ISSUE we", {busy, bus.ram_we}, 2'b11);
        step();
        check("mid-write WAIT", {busy, bus.ram_we, bus.cpu_ack}, 3'b100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("no ack after reset in WAIT", {bus.cpu_ack, busy}, 2'b00);
        lat = 0;
        while (lat < 10 && !bus.cpu_ack) begin
            step();
            lat++;
        end
        check("held write served after reset", lat, 3);
        idle_inputs();
        step();
        shadow[13'h0042] = 8'h77;
        check("mem after re-served write", mem[13'h0042], 8'h77);

        // Reset in the IDLE grant cycle: nothing is written until the request is re-arbitrated.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0055; bus.cpu_wdata = 8'h99;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("grant-cycle reset we/busy", {bus.ram_we, busy}, 2'b00);
        step();
        check("mem untouched by reset grant", mem[13'h0055], 8'h00);
        check("re-arbitrated write issues", bus.ram_we, 1);
        lat = 1;
        while (lat < 10 && !bus.cpu_ack) begin
            step();
            lat++;
        end
        check("re-arbitrated write latency", lat, 3);
        idle_inputs();
        step();
        shadow[13'h0055] = 8'h99;
        check("mem after re-arbitrated write", mem[13'h0055], 8'h99);

        // Randomized traffic against the transaction-level model.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        free_at = 0; p_cyc = -10; starve_m = 0; cpu_start = 0;
        p_cpu = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        exp_vrd = '0; exp_crd = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!bus.vid_req && $urandom_range(2) == 0) begin
                bus.vid_req = 1'b1; bus.vid_addr = rand_addr();
            end
            if (!bus.cpu_req && $urandom_range(3) == 0) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(1));
                bus.cpu_addr = rand_addr(); bus.cpu_wdata = DW'($urandom); cpu_start = c;
            end
            if (c >= free_at && (bus.vid_req || bus.cpu_req)) begin
                p_cyc   = c;
                free_at = c + 4;
                p_cpu   = bus.cpu_req && (!bus.vid_req || starve_m >= CPU_MAX_WAIT);
                p_we    = p_cpu && bus.cpu_we;
                p_addr  = p_cpu ? bus.cpu_addr : bus.vid_addr;
                p_wdata = bus.cpu_wdata;
                if (p_cpu) starve_m = 0;
                else if (bus.cpu_req && starve_m < CPU_MAX_WAIT) starve_m++;
                if (p_we) shadow[p_addr] = p_wdata;
                else if (p_cpu) exp_crd = shadow[p_addr];
                else exp_vrd = shadow[p_addr];
            end
            step();
            o      = c + 1;
            e_vack = !p_cpu && (o == p_cyc + 3);
            e_cack = p_cpu && (o == p_cyc + 3);
            e_busy = (o > p_cyc) && (o <= p_cyc + 3);
            e_we   = p_we && (o == p_cyc + 1);
            check($sformatf("rand cyc%0d ack/busy/we", o),
                  {bus.vid_ack, bus.cpu_ack, busy, bus.ram_we}, {e_vack, e_cack, e_busy, e_we});
            if (o == p_cyc + 1) check("rand ram_addr", bus.ram_addr, p_addr);
            if (e_we) check("rand ram_wdata", bus.ram_wdata, p_wdata);
            if (bus.vid_ack) begin
                check("rand vid_rdata", bus.vid_rdata, exp_vrd);
                bus.vid_req = 1'b0;
            end
            if (bus.cpu_ack) begin
                check("rand cpu_rdata", bus.cpu_rdata, exp_crd);
                check("rand cpu latency bound", (o - cpu_start) <= LAT_BOUND, 1);
                bus.cpu_req = 1'b0;
            end
        end

        check("vid_ack and cpu_ack never together", both_ack_cycles, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
